div_controller: RTL and testbench
=================================

DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-003 SHALL have ports: start  input  1  request a divide; sampled only in IDLE.
REQ-004 SHALL have ports: sign  input  1  datapath adder MSB (1 = remainder_hi minus divisor is negative).
REQ-005 SHALL have ports: load  output  1  datapath divisor-register load enable.
REQ-006 SHALL have ports: add  output  1  datapath adder mode (1 = add, 0 = subtract).
REQ-007 SHALL have ports: shift  output  1  datapath shift-left-by-1 enable.
REQ-008 SHALL have ports: inbit  output  1  bit shifted into remainder register bit 0.
REQ-009 SHALL have ports: sel  output  2  datapath mux select (01 = adder/low, 10 = zero/dividendin, 11 = hold).
REQ-010 SHALL have ports: busy  output  1  high from LOAD through the last ITER cycle.
REQ-011 SHALL have ports: done  output  1  one-cycle pulse; results valid on the datapath outputs.
REQ-012 SHALL use the parameter ITERS, default 8, meaning the number of quotient bits.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, ITER and DONE, with a 3-bit iteration counter cnt.
REQ-014 IDLE SHALL drive load=0, add=0, shift=0, inbit=0, sel=11, busy=0 and done=0; start=1 SHALL move the FSM to LOAD.
REQ-015 LOAD (one cycle) SHALL drive load=1, sel=10, shift=1, inbit=0, add=0, busy=1, giving remainder={8'h00,dividendin}<<1; it SHALL clear cnt and move to ITER.
REQ-016 ITER SHALL drive add=0, shift=1, busy=1 and load=0.
REQ-017 In ITER, sign=0 SHALL drive sel=01 and inbit=1 (commit the subtraction, shift in quotient bit 1).
REQ-018 In ITER, sign=1 SHALL drive sel=11 and inbit=0 (keep the old remainder, shift in quotient bit 0); no separate restore cycle is used.
REQ-019 ITER SHALL increment cnt each cycle and move to DONE after the cycle in which cnt==ITERS-1.
REQ-020 DONE (one cycle) SHALL drive done=1, sel=11, shift=0 and busy=0, then move to IDLE.
REQ-021 Latency SHALL be fixed: start sampled at edge E0 gives LOAD after E0, ITER cycles after E1..E8, and done=1 after E9; the datapath holds its results until the next LOAD.
REQ-022 start SHALL be ignored outside IDLE, and a start held high SHALL begin a new divide on the edge that leaves DONE->IDLE sampled next (IDLE samples start).
REQ-023 sign SHALL be consumed only in ITER; its value in other states is don't-care.
REQ-024 Divisor=0 SHALL complete normally (sign stays 0), giving quotient=8'hFF and remainder=dividend[6:0]; no error flag.
REQ-025 Operand range: divisor 7 bits, dividend 8 bits; the 8-bit sign SHALL be valid because remainder_hi < 2*divisor always holds.
REQ-026 All outputs SHALL be decoded from registered state only (Moore), except sel and inbit in ITER, which depend combinationally on sign.

Reset
REQ-027 reset=0 at a rising clk SHALL force IDLE and cnt=0 regardless of state, including mid-ITER.
REQ-028 During and after reset, outputs SHALL equal the IDLE values (sel=11, all others 0); an aborted divide produces no done pulse.

Structure
REQ-029 A shared package SHALL hold the state enum, the sel encodings (SEL_ADDER=2'b01, SEL_LOAD=2'b10, SEL_HOLD=2'b11) and ITERS.
REQ-030 The block SHALL have no sub-module; the counter and FSM are inline. A wrapper divider_top SHALL instantiate div_controller plus the datapath.

Verification
REQ-031 dividend=100, divisor=7, start pulse -> done after E9, quotient=14, remainder=2.
REQ-032 dividend=255, divisor=1 -> quotient=255, remainder=0; ITER inbit=1 all 8 cycles.
REQ-033 dividend=5, divisor=9 -> quotient=0, remainder=5; sel=11 in all ITER cycles.
REQ-034 dividend=200, divisor=0 -> quotient=8'hFF, remainder=72.
REQ-035 reset=0 in the 4th ITER cycle -> IDLE next cycle, no done; a new start then runs 127/127 -> quotient=1, remainder=0.
REQ-036 start held high continuously -> back-to-back divides, done pulses every 11 cycles, start ignored while busy.

Source files
------------

// File: rtl/div_controller_pkg.sv
// rtl/div_controller_pkg.sv - shared types and encodings for the restoring-divide controller
package div_controller_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_ITER = 2'b10,
      S_DONE = 2'b11
   } state_e;

   localparam logic [1:0] SEL_ADDER = 2'b01;
   localparam logic [1:0] SEL_LOAD  = 2'b10;
   localparam logic [1:0] SEL_HOLD  = 2'b11;

   localparam int ITERS = 8;

endpackage

// File: rtl/divider_top.sv
// rtl/divider_top.sv - 8-bit by 7-bit divider: controller plus remainder/divisor datapath
module divider_top (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] dividendin,
   input  logic [6:0] divisorin,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       busy,
   output logic       done
);
   import div_controller_pkg::*;

   logic        load, add, shift, inbit, sign;
   logic [1:0]  sel;
   logic [15:0] rem_q, rem_d, mux;
   logic [7:0]  dvs_q;
   logic [8:0]  alu;

   div_controller u_ctrl (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sign  (sign),
      .load  (load),
      .add   (add),
      .shift (shift),
      .inbit (inbit),
      .sel   (sel),
      .busy  (busy),
      .done  (done)
   );

   // Ninth bit is the borrow, so a zero divisor never reads as negative.
   assign alu  = add ? ({1'b0, rem_q[15:8]} + {1'b0, dvs_q})
                     : ({1'b0, rem_q[15:8]} - {1'b0, dvs_q});
   assign sign = alu[8];

   always_comb begin
      case (sel)
         SEL_ADDER: mux = {alu[7:0], rem_q[7:0]};
         SEL_LOAD:  mux = {8'h00, dividendin};
         default:   mux = rem_q;
      endcase
      rem_d = shift ? {mux[14:0], inbit} : mux;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rem_q <= 16'h0000;
         dvs_q <= 8'h00;
      end else begin
         rem_q <= rem_d;
         if (load) dvs_q <= {1'b0, divisorin};
      end
   end

   assign quotient  = rem_q[7:0];
   assign remainder = rem_q[15:8] >> 1;

endmodule

// File: rtl/div_controller.sv
// rtl/div_controller.sv - sequencing FSM for a shift/subtract restoring divider datapath
module div_controller #(
   parameter int ITERS = div_controller_pkg::ITERS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       sign,
   output logic       load,
   output logic       add,
   output logic       shift,
   output logic       inbit,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done
);
   import div_controller_pkg::*;

   localparam logic [2:0] LAST_CNT = 3'(ITERS - 1);

   state_e     state_q;
   logic [2:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         case (state_q)
            S_IDLE: if (start) state_q <= S_LOAD;
            S_LOAD: begin
               cnt_q   <= 3'd0;
               state_q <= S_ITER;
            end
            S_ITER: begin
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == LAST_CNT) state_q <= S_DONE;
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // A negative trial difference simply keeps the old remainder, so no restore cycle is needed.
   always_comb begin
      load  = 1'b0;
      add   = 1'b0;
      shift = 1'b0;
      inbit = 1'b0;
      sel   = SEL_HOLD;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         S_LOAD: begin
            load  = 1'b1;
            sel   = SEL_LOAD;
            shift = 1'b1;
            busy  = 1'b1;
         end
         S_ITER: begin
            shift = 1'b1;
            busy  = 1'b1;
            inbit = ~sign;
            sel   = sign ? SEL_HOLD : SEL_ADDER;
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_div_controller.sv
// tb/tb_div_controller.sv - scoreboard bench for div_controller and the divider_top wrapper
module tb_div_controller;
   import div_controller_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       sign = 1'b0;
   logic       load, add, shift, inbit, busy, done;
   logic [1:0] sel;
   logic [7:0] dividend = 8'd0;
   logic [6:0] divisor = 7'd0;
   logic [7:0] quotient, remainder;
   logic       top_busy, top_done;

   always #5 clk = ~clk;

   div_controller dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sign  (sign),
      .load  (load),
      .add   (add),
      .shift (shift),
      .inbit (inbit),
      .sel   (sel),
      .busy  (busy),
      .done  (done)
   );

   divider_top u_top (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dividendin (dividend),
      .divisorin  (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .busy       (top_busy),
      .done       (top_done)
   );

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
   } exp_t;

   int   n_tests = 0;
   int   n_fail = 0;
   int   ph = -1;   // -1 idle, 0 load, 1..8 iteration number, 9 done
   int   cyc = 0;
   logic [7:0] cur_q = 8'd0;
   exp_t sb[$];
   int   done_cyc[$];

   function automatic exp_t ref_div(input logic [7:0] a, input logic [6:0] b);
      exp_t e;
      if (b == 7'd0) begin
         e.q = 8'hFF;
         e.r = {1'b0, a[6:0]};
      end else begin
         e.q = a / {1'b0, b};
         e.r = a % {1'b0, b};
      end
      return e;
   endfunction

   function automatic logic [7:0] exp_ctrl(input int p, input logic qb);
      if (p == 0)            return {1'b1, 1'b0, 1'b1, 1'b0, SEL_LOAD, 1'b1, 1'b0};
      if (p >= 1 && p <= 8)  return {1'b0, 1'b0, 1'b1, qb, (qb ? SEL_ADDER : SEL_HOLD), 1'b1, 1'b0};
      if (p == 9)            return {1'b0, 1'b0, 1'b0, 1'b0, SEL_HOLD, 1'b0, 1'b1};
      return {1'b0, 1'b0, 1'b0, 1'b0, SEL_HOLD, 1'b0, 1'b0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Timeline of the expected divide phases, advanced on the same edge the DUT samples.
   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         ph = -1;
         sb.delete();
      end else if (ph == -1) ph = start ? 0 : -1;
      else if (ph == 9)      ph = -1;
      else                   ph++;
   end

   always @(negedge clk) begin
      exp_t e;
      logic qb;
      if (ph == 0) begin
         e = ref_div(dividend, divisor);
         sb.push_back(e);
         cur_q = e.q;
      end
      qb   = (ph >= 1 && ph <= 8) ? cur_q[8 - ph] : 1'b0;
      sign = (ph >= 1 && ph <= 8) ? ~qb : 1'($urandom);
      #1;
      check($sformatf("ctrl_ph%0d", ph), {load, add, shift, inbit, sel, busy, done}, exp_ctrl(ph, qb));
      if (top_done) begin
         done_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 expected no result pending", cyc);
         end else begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
         end
      end
   end

   task automatic wait_ph(input int target, input int budget);
      for (int i = 0; i < budget && ph != target; i++) begin
         @(posedge clk);
         #2;
      end
      if (ph != target) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_ph timeout: got phase %0d expected %0d", ph, target);
      end
   endtask

   task automatic run_div(input logic [7:0] a, input logic [6:0] b);
      wait_ph(-1, 40);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;

      run_div(8'd100, 7'd7);
      run_div(8'd255, 7'd1);
      run_div(8'd5,   7'd9);
      run_div(8'd200, 7'd0);

      // Abort in the 4th iteration cycle; no done may follow.
      run_div(8'd50, 7'd3);
      wait_ph(4, 20);
      reset = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #2;
      run_div(8'd127, 7'd127);

      for (int k = 0; k < 20; k++)
         run_div(8'($urandom_range(0, 255)), (k % 7 == 0) ? 7'd0 : 7'($urandom_range(1, 127)));

      // Start held high: back-to-back divides.
      wait_ph(-1, 40);
      n0 = done_cyc.size();
      dividend = 8'($urandom_range(0, 255));
      divisor  = 7'($urandom_range(1, 127));
      start    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #2;
         wait_ph(9, 30);
         dividend = 8'($urandom_range(0, 255));
         divisor  = 7'($urandom_range(0, 127));
         if (k == 3) start = 1'b0;
      end
      repeat (4) @(posedge clk);
      #2;
      check("b2b_done_count", done_cyc.size() - n0, 4);
      for (int k = n0 + 1; k < done_cyc.size(); k++)
         check("b2b_interval", done_cyc[k] - done_cyc[k - 1], 11);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
